// File: rtl/port_tx.sv
// port_tx: egress side of a switch port.
//   Accepts one packet header (priority, length) from the switch core plus a
//   stream of payload words, buffers the payload in a small FIFO and emits
//   rd_sop, a regenerated control word, `length` payload words, then rd_eop.
//   The control word layout is {length[8:0], prior[2:0], PORT_ID[3:0]}, the
//   same layout the ingress side parses.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   hdr_vld/hdr_prior/hdr_length       header from core; hdr_ready = accepted
//   in_vld/in_data/in_last, in_ready   payload words into the FIFO
//   tx_ready                           downstream permits a new packet
//   rd_sop/rd_vld/rd_data/rd_eop       packet output
//   busy                               FSM not idle
//   err_len                            pulse on in_last / length disagreement
//   pkt_cnt                            completed packets (wraps)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a header (hdr_ready = 1)
// ST_HOLD  | header latched, waiting for tx_ready
// ST_SOP   | rd_sop shown this cycle
// ST_CTRL  | control word shown this cycle
// ST_DATA  | payload phase: a popped word or an underrun gap is shown
// ST_EOP   | rd_eop shown this cycle, pkt_cnt already advanced
module port_tx #(
    parameter logic [3:0] PORT_ID    = 4'd0,
    parameter int         FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hdr_vld,
    input  logic [2:0]  hdr_prior,
    input  logic [8:0]  hdr_length,
    output logic        hdr_ready,
    input  logic        in_vld,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        tx_ready,
    output logic        rd_sop,
    output logic        rd_vld,
    output logic [15:0] rd_data,
    output logic        rd_eop,
    output logic        busy,
    output logic        err_len,
    output logic [15:0] pkt_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SOP,
        ST_CTRL,
        ST_DATA,
        ST_EOP
    } state_t;

    state_t state, state_next;

    // ---------------- payload FIFO ----------------
    logic [16:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, fifo_empty;
    logic [16:0]      head;

    assign in_ready   = (count != FULL_CNT);
    assign push       = in_vld && in_ready;
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_last, in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- packet FSM ----------------
    logic [2:0]  prior;
    logic [8:0]  length;
    logic [8:0]  remain;
    logic        sop_n, vld_n, eop_n, err_n;
    logic [15:0] data_n;
    logic        hdr_acc, cnt_inc;

    assign hdr_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Outputs are registered alongside the state, so every decision below
    // describes what will be visible in the cycle after this edge. The pop
    // for a payload word happens on the edge that starts its output cycle.
    always_comb begin
        state_next = state;
        sop_n      = 1'b0;
        vld_n      = 1'b0;
        eop_n      = 1'b0;
        err_n      = 1'b0;
        data_n     = rd_data;
        pop        = 1'b0;
        hdr_acc    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hdr_vld) begin
                    hdr_acc    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tx_ready) begin
                    sop_n      = 1'b1;
                    state_next = ST_SOP;
                end
            end
            ST_SOP: begin
                vld_n      = 1'b1;
                data_n     = {length, prior, PORT_ID};
                state_next = ST_CTRL;
            end
            ST_CTRL, ST_DATA: begin
                if (remain == 9'd0) begin
                    eop_n      = 1'b1;
                    cnt_inc    = 1'b1;
                    state_next = ST_EOP;
                end else begin
                    state_next = ST_DATA;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        vld_n  = 1'b1;
                        data_n = head[15:0];
                        // in_last must be set exactly on the word that
                        // exhausts the header length
                        err_n  = head[16] ^ (remain == 9'd1);
                    end
                end
            end
            ST_EOP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rd_sop  <= 1'b0;
            rd_vld  <= 1'b0;
            rd_eop  <= 1'b0;
            err_len <= 1'b0;
            rd_data <= '0;
            pkt_cnt <= '0;
            prior   <= '0;
            length  <= '0;
            remain  <= '0;
        end else begin
            state   <= state_next;
            rd_sop  <= sop_n;
            rd_vld  <= vld_n;
            rd_eop  <= eop_n;
            err_len <= err_n;
            rd_data <= data_n;
            if (cnt_inc) pkt_cnt <= pkt_cnt + 16'd1;
            if (hdr_acc) begin
                prior  <= hdr_prior;
                length <= hdr_length;
                remain <= hdr_length;
            end else if (pop) begin
                remain <= remain - 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_port_tx.sv
// tb_port_tx: directed scoreboard bench for port_tx (PORT_ID = 7).
//   Expected output events (sop, data words, err_len, eop) are queued when a
//   packet is issued; a negedge monitor pops and compares every event the DUT
//   shows. Timing properties are checked from cycle stamps the monitor keeps.
module tb_port_tx;

    localparam logic [1:0] K_SOP = 2'd0, K_VLD = 2'd1, K_ERR = 2'd2, K_EOP = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_vld = 1'b0;
    logic [2:0]  hdr_prior = '0;
    logic [8:0]  hdr_length = '0;
    logic        hdr_ready;
    logic        in_vld = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        tx_ready = 1'b1;
    logic        rd_sop, rd_vld, rd_eop, busy, err_len;
    logic [15:0] rd_data, pkt_cnt;

    port_tx #(.PORT_ID(4'h7), .FIFO_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_vld(hdr_vld), .hdr_prior(hdr_prior), .hdr_length(hdr_length),
        .hdr_ready(hdr_ready),
        .in_vld(in_vld), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .tx_ready(tx_ready),
        .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data), .rd_eop(rd_eop),
        .busy(busy), .err_len(err_len), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } ev_t;

    ev_t         expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          sop_cyc = -1;
    int          eop_cyc = -1;
    int          b2b_gap = -1;
    int          eop_count = 0;
    int          vcyc[$];
    logic [15:0] vdat[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic expect_pkt(input logic [15:0] ctrl, input logic [15:0] w[$]);
        expect_ev(K_SOP, 16'h0);
        expect_ev(K_VLD, ctrl);
        foreach (w[i]) expect_ev(K_VLD, w[i]);
        expect_ev(K_EOP, 16'h0);
    endtask

    task automatic mon_pop(input logic [1:0] k, input logic [15:0] d);
        ev_t e;
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
        end else begin
            e = expq.pop_front();
            check("event", {k, d}, {e.kind, e.data});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (rd_sop) begin
                if (eop_cyc >= 0) b2b_gap = cyc - eop_cyc;
                sop_cyc = cyc;
                mon_pop(K_SOP, 16'h0);
            end
            if (rd_vld) begin
                vcyc.push_back(cyc);
                vdat.push_back(rd_data);
                mon_pop(K_VLD, rd_data);
            end
            if (err_len) mon_pop(K_ERR, 16'h0);
            if (rd_eop) begin
                eop_cyc = cyc;
                eop_count++;
                mon_pop(K_EOP, 16'h0);
            end
        end
    end

    // All driver tasks start and end at 1 ns after a rising edge.
    task automatic push_word(input logic [15:0] d, input logic last);
        int n = 0;
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_hdr(input logic [2:0] p, input logic [8:0] len);
        int n = 0;
        hdr_vld    = 1'b1;
        hdr_prior  = p;
        hdr_length = len;
        while (!hdr_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!hdr_ready) check("hdr_timeout", 0, 1);
        @(posedge clk); #1;
        hdr_vld = 1'b0;
    endtask

    task automatic wait_pkts(input int target);
        int n = 0;
        while (eop_count < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (eop_count < target) check("eop_timeout", eop_count, target);
    endtask

    initial begin
        logic [15:0] w[$];
        int          n;
        int          eop_base;

        // reset state
        #2;
        check("reset_outputs", {rd_sop, rd_vld, rd_eop, err_len, busy, rd_data, pkt_cnt}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_after_reset", {hdr_ready, in_ready}, 2'b11);

        // single packet: prior 5, length 3 -> ctrl 0x01D7
        push_word(16'hA001, 1'b0);
        push_word(16'hA002, 1'b0);
        push_word(16'hA003, 1'b1);
        w = '{16'hA001, 16'hA002, 16'hA003};
        expect_pkt(16'h01D7, w);
        send_hdr(3'd5, 9'd3);
        wait_pkts(1);
        check("single_sop_to_eop", eop_cyc - sop_cyc, 5);
        check("pkt_cnt_1", pkt_cnt, 1);

        // FIFO full: 33 pushes, no header
        for (int i = 0; i < 33; i++) begin
            in_vld  = 1'b1;
            in_data = 16'h5000 + 16'(i);
            in_last = (i == 31);
            @(posedge clk); #1;
            if (i == 30) check("in_ready_before_full", in_ready, 1);
            if (i == 31) check("in_ready_full", in_ready, 0);
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
        check("in_ready_still_full", in_ready, 0);
        w.delete();
        for (int i = 0; i < 32; i++) w.push_back(16'h5000 + 16'(i));
        expect_pkt(16'h1027, w);
        send_hdr(3'd2, 9'd32);
        wait_pkts(2);
        check("in_ready_after_drain", in_ready, 1);
        check("pkt_cnt_2", pkt_cnt, 2);

        // backpressure: tx_ready low for 10 cycles after the header
        tx_ready = 1'b0;
        push_word(16'hD001, 1'b1);
        w = '{16'hD001};
        expect_pkt(16'h0097, w);
        send_hdr(3'd1, 9'd1);
        for (int i = 0; i < 10; i++) begin
            check("hold_state", {busy, hdr_ready, rd_sop}, 3'b100);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check("sop_after_tx_ready", rd_sop, 1);
        wait_pkts(3);
        check("pkt_cnt_3", pkt_cnt, 3);

        // underrun: length 4, third word delayed so 5 idle cycles appear
        vcyc.delete();
        vdat.delete();
        push_word(16'hC001, 1'b0);
        push_word(16'hC002, 1'b0);
        w = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        expect_pkt(16'h0267, w);
        send_hdr(3'd6, 9'd4);
        n = 0;
        while (vdat.size() < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("underrun_w2_seen", vdat.size() >= 3, 1);
        repeat (3) @(posedge clk);
        #1;
        push_word(16'hC003, 1'b0);
        push_word(16'hC004, 1'b1);
        wait_pkts(4);
        if (vcyc.size() == 5) begin
            check("underrun_gap", vcyc[3] - vcyc[2], 6);
            check("underrun_w4_next", vcyc[4] - vcyc[3], 1);
            check("underrun_eop_after_w4", eop_cyc - vcyc[4], 1);
        end else begin
            check("underrun_vld_count", vcyc.size(), 5);
        end

        // mismatch: length 2, in_last on word 1; then zero length back-to-back
        push_word(16'hB001, 1'b1);
        push_word(16'hB002, 1'b1);
        expect_ev(K_SOP, 16'h0);
        expect_ev(K_VLD, 16'h0137);
        expect_ev(K_VLD, 16'hB001);
        expect_ev(K_ERR, 16'h0);
        expect_ev(K_VLD, 16'hB002);
        expect_ev(K_EOP, 16'h0);
        w.delete();
        expect_pkt(16'h0007, w);
        send_hdr(3'd3, 9'd2);
        send_hdr(3'd0, 9'd0);
        wait_pkts(6);
        check("b2b_eop_to_sop", b2b_gap, 3);
        check("zero_sop_to_eop", eop_cyc - sop_cyc, 2);
        check("pkt_cnt_6", pkt_cnt, 6);

        // reset while in DATA
        vdat.delete();
        push_word(16'hE001, 1'b0);
        push_word(16'hE002, 1'b0);
        push_word(16'hE003, 1'b1);
        w = '{16'hE001, 16'hE002, 16'hE003};
        expect_pkt(16'h0187, w);
        send_hdr(3'd0, 9'd3);
        n = 0;
        while (vdat.size() < 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("data_phase_reached", busy, 1);
        eop_base = eop_count;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {rd_sop, rd_vld, rd_eop, err_len, busy, rd_data, pkt_cnt}, 0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("after_reset_state", {pkt_cnt, busy, in_ready, hdr_ready}, {16'd0, 3'b011});
        repeat (3) @(posedge clk);
        #1;
        check("no_eop_on_abort", eop_count, eop_base);
        push_word(16'hF001, 1'b1);
        w = '{16'hF001};
        expect_pkt(16'h0087, w);
        send_hdr(3'd0, 9'd1);
        wait_pkts(eop_base + 1);
        check("pkt_cnt_after_reset", pkt_cnt, 1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_tx.md
Name: port_tx

Overview:
- Egress counterpart of the ingress port. Takes one packet header plus a stream of payload words from the switch core.
- Buffers the payload in a 32-entry FIFO and emits the packet on the port's output interface as rd_sop, then a control frame, then the payload words, then rd_eop.
- Regenerates the control frame with the same field layout the ingress side parses: [3:0] port, [6:4] priority, [15:7] length.

Parameters:
- PORT_ID, 4'd0, port number written into ctrl word bits [3:0].
- FIFO_DEPTH, 32, payload FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hdr_vld  in  1  header offered by core.
- hdr_prior  in  3  packet priority.
- hdr_length  in  9  payload length in 16-bit words (0..511).
- hdr_ready  out  1  header accepted when hdr_vld && hdr_ready.
- in_vld  in  1  payload word offered.
- in_data  in  16  payload word.
- in_last  in  1  marks the core's final payload word.
- in_ready  out  1  FIFO can accept a word.
- tx_ready  in  1  downstream may start a packet.
- rd_sop  out  1  start-of-packet pulse.
- rd_vld  out  1  rd_data valid.
- rd_data  out  16  control word or payload word.
- rd_eop  out  1  end-of-packet pulse.
- busy  out  1  state is not IDLE.
- err_len  out  1  one-cycle pulse on an in_last / length mismatch.
- pkt_cnt  out  16  completed packets, wraps at 65535 to 0.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rd_sop, rd_vld, rd_eop, err_len, busy = 0; rd_data = 0; pkt_cnt = 0.
  - hdr_ready = 1 and in_ready = 1 once out of reset.
  - FIFO is flushed: pointers and count = 0. State = IDLE.
  - Reset mid-packet aborts the packet. No rd_eop is emitted and pkt_cnt is not incremented.
- Payload FIFO:
  - 17 bits wide ({in_last, in_data}), FIFO_DEPTH entries.
  - Pointers wrap modulo FIFO_DEPTH.
  - in_ready = (count != FIFO_DEPTH). A write happens when in_vld && in_ready.
  - A simultaneous push and pop leaves count unchanged.
  - A push into an empty FIFO is poppable on the next cycle, not the same cycle.
  - The FIFO accepts words in any state, so the core may prefill before or during the header.
- Header: hdr_ready = (state == IDLE). On acceptance, prior and length are latched and remain := hdr_length.
- FSM. All outputs are registered; each bullet is one clock cycle.
  - IDLE: outputs deasserted. On header accept, go to HOLD.
  - HOLD: wait for tx_ready=1 sampled at a rising edge, then go to SOP. While tx_ready=0 the state stays HOLD indefinitely.
  - SOP: rd_sop=1 for exactly one cycle, rd_vld=0. Go to CTRL.
  - CTRL: rd_vld=1, rd_data = {length[8:0], prior[2:0], PORT_ID[3:0]}.
    - If remain == 0, go to EOP.
    - Otherwise go to DATA.
  - DATA: each cycle with FIFO non-empty, pop one entry, drive rd_vld=1 and rd_data = the entry's data, and decrement remain.
    - FIFO empty: rd_vld=0 and rd_data holds its last value. These gaps are legal.
    - The pop that brings remain to 0 moves the FSM to EOP.
  - EOP: rd_eop=1 for one cycle, rd_vld=0, pkt_cnt increments. Return to IDLE.
- tx_ready is sampled only in HOLD. Deasserting it mid-packet has no effect.
- Back-to-back packets: with tx_ready held at 1, the minimum gap is fixed by the state sequence. From the rd_eop cycle to the next rd_sop cycle takes 3 cycles: EOP, IDLE (header accept), HOLD.
- Length check, on each DATA pop:
  - Popped word has in_last=1 while remain != 1: err_len pulses next cycle.
  - Popped word has remain == 1 and in_last=0: err_len pulses next cycle.
  - In both cases transmission still emits exactly `length` payload words. Any surplus core words stay in the FIFO for the next packet.
- Zero length: rd_sop, the ctrl word, then rd_eop. No payload words are popped.

Test Plan:
- Single packet: reset, preload 3 words 0xA001/0xA002/0xA003 (last on the third), header prior=5, length=3, PORT_ID=4'h7, tx_ready=1.
  - Required: rd_sop for one cycle, then a ctrl word of 16'h01D7.
  - Then the 3 payload words on consecutive cycles, then rd_eop; pkt_cnt=1, err_len never pulses.
- Backpressure and hold: tx_ready=0 for 10 cycles after the header.
  - Required: no rd_sop, busy=1, hdr_ready=0.
  - When tx_ready rises, rd_sop follows on the next cycle.
- FIFO full: push 33 words with no header.
  - Required: in_ready drops after the 32nd word and the 33rd is not accepted.
  - After a 32-word packet drains, in_ready=1 and the count wraps correctly.
- Underrun: length=4, word 3 delayed 5 cycles.
  - Required: rd_vld low exactly 5 cycles between words 2 and 3.
  - rd_eop only after word 4.
- Mismatch and zero length: length=2 with in_last on word 1.
  - Required: err_len pulse after the first pop, and 2 words still emitted.
  - Then a length=0 packet gives sop, ctrl 16'h0007 (prior=0), eop.
- Reset mid-packet: assert rst_n=0 in DATA.
  - Required: all outputs 0 asynchronously, no rd_eop, pkt_cnt=0, FIFO empty after reset.
